// File: rtl/instr_encoder_pkg.sv
// Shared MIPS32 constants: request mnemonics, opcode/funct values and word packers.
package instr_encoder_pkg;

  // Request mnemonics as seen on in_op; codes outside this range are rejected.
  typedef enum logic [5:0] {
    OpAddu    = 6'd0,
    OpAdd     = 6'd1,
    OpSubu    = 6'd2,
    OpSub     = 6'd3,
    OpAnd     = 6'd4,
    OpOr      = 6'd5,
    OpXor     = 6'd6,
    OpNor     = 6'd7,
    OpSlt     = 6'd8,
    OpSltu    = 6'd9,
    OpSll     = 6'd10,
    OpSrl     = 6'd11,
    OpSra     = 6'd12,
    OpSllv    = 6'd13,
    OpSrlv    = 6'd14,
    OpSrav    = 6'd15,
    OpJr      = 6'd16,
    OpJalr    = 6'd17,
    OpSyscall = 6'd18,
    OpAddiu   = 6'd19,
    OpAddi    = 6'd20,
    OpOri     = 6'd21,
    OpXori    = 6'd22,
    OpAndi    = 6'd23,
    OpSlti    = 6'd24,
    OpSltiu   = 6'd25,
    OpLw      = 6'd26,
    OpSw      = 6'd27,
    OpBeq     = 6'd28,
    OpBne     = 6'd29,
    OpBlez    = 6'd30,
    OpBgtz    = 6'd31,
    OpBltz    = 6'd32,
    OpBgez    = 6'd33,
    OpLui     = 6'd34,
    OpJ       = 6'd35,
    OpJal     = 6'd36,
    OpNop     = 6'd37,
    OpLi      = 6'd38
  } op_e;

  localparam int unsigned NumOps = 39;

  typedef enum logic {
    StIdle,
    StSecond
  } state_e;

  // Primary opcodes
  localparam logic [5:0] OpcSpecial = 6'h00;
  localparam logic [5:0] OpcRegimm  = 6'h01;
  localparam logic [5:0] OpcJ       = 6'h02;
  localparam logic [5:0] OpcJal     = 6'h03;
  localparam logic [5:0] OpcBeq     = 6'h04;
  localparam logic [5:0] OpcBne     = 6'h05;
  localparam logic [5:0] OpcBlez    = 6'h06;
  localparam logic [5:0] OpcBgtz    = 6'h07;
  localparam logic [5:0] OpcAddi    = 6'h08;
  localparam logic [5:0] OpcAddiu   = 6'h09;
  localparam logic [5:0] OpcSlti    = 6'h0A;
  localparam logic [5:0] OpcSltiu   = 6'h0B;
  localparam logic [5:0] OpcAndi    = 6'h0C;
  localparam logic [5:0] OpcOri     = 6'h0D;
  localparam logic [5:0] OpcXori    = 6'h0E;
  localparam logic [5:0] OpcLui     = 6'h0F;
  localparam logic [5:0] OpcLw      = 6'h23;
  localparam logic [5:0] OpcSw      = 6'h2B;

  // SPECIAL funct codes
  localparam logic [5:0] FnSll     = 6'h00;
  localparam logic [5:0] FnSrl     = 6'h02;
  localparam logic [5:0] FnSra     = 6'h03;
  localparam logic [5:0] FnSllv    = 6'h04;
  localparam logic [5:0] FnSrlv    = 6'h06;
  localparam logic [5:0] FnSrav    = 6'h07;
  localparam logic [5:0] FnJr      = 6'h08;
  localparam logic [5:0] FnJalr    = 6'h09;
  localparam logic [5:0] FnSyscall = 6'h0C;
  localparam logic [5:0] FnAdd     = 6'h20;
  localparam logic [5:0] FnAddu    = 6'h21;
  localparam logic [5:0] FnSub     = 6'h22;
  localparam logic [5:0] FnSubu    = 6'h23;
  localparam logic [5:0] FnAnd     = 6'h24;
  localparam logic [5:0] FnOr      = 6'h25;
  localparam logic [5:0] FnXor     = 6'h26;
  localparam logic [5:0] FnNor     = 6'h27;
  localparam logic [5:0] FnSlt     = 6'h2A;
  localparam logic [5:0] FnSltu    = 6'h2B;

  // REGIMM rt selectors
  localparam logic [4:0] RtBltz = 5'd0;
  localparam logic [4:0] RtBgez = 5'd1;

  function automatic logic [31:0] pack_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                         logic [4:0] shamt, logic [5:0] funct);
    return {OpcSpecial, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [31:0] pack_i(logic [5:0] opc, logic [4:0] rs, logic [4:0] rt,
                                         logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  function automatic logic [31:0] pack_j(logic [5:0] opc, logic [25:0] target);
    return {opc, target};
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request and emitted-word handshake bundle of the instruction encoder.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_op;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [31:0] out_addr;

  // Requester / word consumer side
  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_imm, out_ready,
    input  in_ready, out_valid, out_word, out_addr
  );

  // Encoder side
  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm, out_ready,
    output in_ready, out_valid, out_word, out_addr
  );
endinterface

// File: rtl/instr_field_pack.sv
// Combinational packer: one mnemonic plus fields -> one MIPS32 word (LI is split upstream).
module instr_field_pack
  import instr_encoder_pkg::*;
(
  input  logic [5:0]  i_op,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [25:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_known
);

  logic [15:0] w_lo;
  logic [4:0]  w_sh;

  assign w_lo = i_imm[15:0];
  assign w_sh = i_imm[4:0];

  // Field placement per mnemonic; unlisted codes flag o_known low.
  always_comb begin
    o_word  = '0;
    o_known = 1'b1;
    case (i_op)
      OpAddu:    o_word = pack_r(i_rs, i_rt, i_rd, 5'd0, FnAddu);
      OpAdd:     o_word = pack_r(i_rs, i_rt, i_rd, 5'd0, FnAdd);
      OpSubu:    o_word = pack_r(i_rs, i_rt, i_rd, 5'd0, FnSubu);
      OpSub:     o_word = pack_r(i_rs, i_rt, i_rd, 5'd0, FnSub);
      OpAnd:     o_word = pack_r(i_rs, i_rt, i_rd, 5'd0, FnAnd);
      OpOr:      o_word = pack_r(i_rs, i_rt, i_rd, 5'd0, FnOr);
      OpXor:     o_word = pack_r(i_rs, i_rt, i_rd, 5'd0, FnXor);
      OpNor:     o_word = pack_r(i_rs, i_rt, i_rd, 5'd0, FnNor);
      OpSlt:     o_word = pack_r(i_rs, i_rt, i_rd, 5'd0, FnSlt);
      OpSltu:    o_word = pack_r(i_rs, i_rt, i_rd, 5'd0, FnSltu);
      OpSll:     o_word = pack_r(5'd0, i_rt, i_rd, w_sh, FnSll);
      OpSrl:     o_word = pack_r(5'd0, i_rt, i_rd, w_sh, FnSrl);
      OpSra:     o_word = pack_r(5'd0, i_rt, i_rd, w_sh, FnSra);
      OpSllv:    o_word = pack_r(i_rs, i_rt, i_rd, 5'd0, FnSllv);
      OpSrlv:    o_word = pack_r(i_rs, i_rt, i_rd, 5'd0, FnSrlv);
      OpSrav:    o_word = pack_r(i_rs, i_rt, i_rd, 5'd0, FnSrav);
      OpJr:      o_word = pack_r(i_rs, 5'd0, 5'd0, 5'd0, FnJr);
      OpJalr:    o_word = pack_r(i_rs, 5'd0, i_rd, 5'd0, FnJalr);
      OpSyscall: o_word = pack_r(5'd0, 5'd0, 5'd0, 5'd0, FnSyscall);
      OpNop:     o_word = pack_r(5'd0, 5'd0, 5'd0, 5'd0, FnSll);
      OpAddiu:   o_word = pack_i(OpcAddiu, i_rs, i_rt, w_lo);
      OpAddi:    o_word = pack_i(OpcAddi, i_rs, i_rt, w_lo);
      OpOri:     o_word = pack_i(OpcOri, i_rs, i_rt, w_lo);
      OpXori:    o_word = pack_i(OpcXori, i_rs, i_rt, w_lo);
      OpAndi:    o_word = pack_i(OpcAndi, i_rs, i_rt, w_lo);
      OpSlti:    o_word = pack_i(OpcSlti, i_rs, i_rt, w_lo);
      OpSltiu:   o_word = pack_i(OpcSltiu, i_rs, i_rt, w_lo);
      OpLw:      o_word = pack_i(OpcLw, i_rs, i_rt, w_lo);
      OpSw:      o_word = pack_i(OpcSw, i_rs, i_rt, w_lo);
      OpBeq:     o_word = pack_i(OpcBeq, i_rs, i_rt, w_lo);
      OpBne:     o_word = pack_i(OpcBne, i_rs, i_rt, w_lo);
      OpBlez:    o_word = pack_i(OpcBlez, i_rs, 5'd0, w_lo);
      OpBgtz:    o_word = pack_i(OpcBgtz, i_rs, 5'd0, w_lo);
      OpBltz:    o_word = pack_i(OpcRegimm, i_rs, RtBltz, w_lo);
      OpBgez:    o_word = pack_i(OpcRegimm, i_rs, RtBgez, w_lo);
      OpLui:     o_word = pack_i(OpcLui, 5'd0, i_rt, w_lo);
      OpJ:       o_word = pack_j(OpcJ, i_imm);
      OpJal:     o_word = pack_j(OpcJal, i_imm);
      default:   o_known = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streams encoded MIPS32 words into consecutive instruction-memory slots, expanding LI.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_3000,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic            clk,
  input  logic            reset,
  instr_encoder_if.slave  bus,
  output logic            full,
  output logic            err
);

  localparam int unsigned   CntW  = $clog2(DEPTH_WORDS + 1);
  localparam logic [CntW-1:0] Depth = CntW'(DEPTH_WORDS);

  state_e          r_state, w_state_d;
  logic            r_out_valid, w_out_valid_d;
  logic [31:0]     r_out_word, w_out_word_d;
  logic [31:0]     r_out_addr, w_out_addr_d;
  logic [31:0]     r_second, w_second_d;
  logic [CntW-1:0] r_reserved, w_reserved_d;
  logic            r_err, w_err_d;

  logic            w_full, w_in_ready, w_in_fire, w_out_fire;
  logic            w_is_li, w_li_two, w_known, w_slot_err;
  logic [15:0]     w_hi, w_lo;
  logic [5:0]      w_pack_op;
  logic [4:0]      w_pack_rs;
  logic [25:0]     w_pack_imm;
  logic [31:0]     w_first_word, w_second_word;
  logic [CntW-1:0] w_free;

  assign w_hi     = bus.in_imm[31:16];
  assign w_lo     = bus.in_imm[15:0];
  assign w_is_li  = (bus.in_op == OpLi);
  assign w_li_two = w_is_li && (w_hi != 16'd0) && (w_lo != 16'd0);

  assign w_full     = (r_reserved == Depth);
  assign w_free     = Depth - r_reserved;
  // Acceptance implies at least one free slot, so a pair only fails with exactly one left
  assign w_slot_err = w_li_two && (w_free == CntW'(1));
  assign w_in_ready = (r_state == StIdle) && (!r_out_valid || bus.out_ready) && !w_full;
  assign w_in_fire  = bus.in_valid && w_in_ready;
  assign w_out_fire = r_out_valid && bus.out_ready;

  // Map LI onto the first word it produces (ORI $0 form, or LUI with the upper half)
  always_comb begin
    w_pack_op  = bus.in_op;
    w_pack_rs  = bus.in_rs;
    w_pack_imm = bus.in_imm[25:0];
    if (w_is_li) begin
      w_pack_rs = 5'd0;
      if (w_hi == 16'd0) begin
        w_pack_op  = OpOri;
        w_pack_imm = {10'd0, w_lo};
      end else begin
        w_pack_op  = OpLui;
        w_pack_imm = {10'd0, w_hi};
      end
    end
  end

  assign w_second_word = pack_i(OpcOri, bus.in_rt, bus.in_rt, w_lo);

  instr_field_pack u_pack (
    .i_op    (w_pack_op),
    .i_rs    (w_pack_rs),
    .i_rt    (bus.in_rt),
    .i_rd    (bus.in_rd),
    .i_imm   (w_pack_imm),
    .o_word  (w_first_word),
    .o_known (w_known)
  );

  // Next-state: accept requests in IDLE, push the held LI low half in SECOND
  always_comb begin
    w_state_d     = r_state;
    w_out_valid_d = r_out_valid && !w_out_fire;
    w_out_word_d  = r_out_word;
    w_out_addr_d  = w_out_fire ? r_out_addr + 32'd4 : r_out_addr;
    w_second_d    = r_second;
    w_reserved_d  = r_reserved;
    w_err_d       = r_err;
    case (r_state)
      StIdle: begin
        if (w_in_fire) begin
          if (!w_known || w_slot_err) begin
            w_err_d = 1'b1;
          end else begin
            w_out_valid_d = 1'b1;
            w_out_word_d  = w_first_word;
            w_reserved_d  = r_reserved + CntW'(1) + (w_li_two ? CntW'(1) : '0);
            if (w_li_two) begin
              w_second_d = w_second_word;
              w_state_d  = StSecond;
            end
          end
        end
      end
      StSecond: begin
        if (!r_out_valid || bus.out_ready) begin
          w_out_valid_d = 1'b1;
          w_out_word_d  = r_second;
          w_state_d     = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_out_valid <= 1'b0;
      r_out_word  <= '0;
      r_out_addr  <= BASE_ADDR;
      r_second    <= '0;
      r_reserved  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_out_valid <= w_out_valid_d;
      r_out_word  <= w_out_word_d;
      r_out_addr  <= w_out_addr_d;
      r_second    <= w_second_d;
      r_reserved  <= w_reserved_d;
      r_err       <= w_err_d;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_word  = r_out_word;
  assign bus.out_addr  = r_out_addr;
  assign full          = w_full;
  assign err           = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed and randomized checks of instr_encoder against an arithmetic reference model.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  localparam int unsigned Depth = 1024;
  localparam logic [31:0] Base  = 32'h0000_3000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic full, err, full2, err2;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_en = 1'b0;

  logic [63:0] m_q[$];
  int unsigned m_reserved;
  bit          m_err;
  logic [31:0] m_next_addr;

  instr_encoder_if bus ();
  instr_encoder_if bus2 ();

  instr_encoder u_dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus),
    .full  (full),
    .err   (err)
  );

  instr_encoder #(.DEPTH_WORDS(2)) u_dut_small (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus2),
    .full  (full2),
    .err   (err2)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;  bus.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.out_ready = 1'b1;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic set_req(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] imm);
    bus.in_op = op; bus.in_rs = rs; bus.in_rt = rt; bus.in_rd = rd; bus.in_imm = imm;
  endtask

  // Reference encoding built from field weights rather than bit concatenation
  function automatic logic [31:0] rr(int unsigned rs, int unsigned rt, int unsigned rd,
                                     int unsigned sh, int unsigned fn);
    return 32'(rs * 2097152 + rt * 65536 + rd * 2048 + sh * 64 + fn);
  endfunction

  function automatic logic [31:0] ri(int unsigned opc, int unsigned rs, int unsigned rt,
                                     int unsigned imm);
    return 32'(opc * 67108864 + rs * 2097152 + rt * 65536 + imm);
  endfunction

  function automatic int ref_encode(input logic [5:0] op, input int unsigned rs,
                                    input int unsigned rt, input int unsigned rd,
                                    input logic [31:0] imm, output logic [31:0] w0,
                                    output logic [31:0] w1);
    int unsigned lo = imm % 65536;
    int unsigned hi = imm / 65536;
    int unsigned sh = imm % 32;
    int unsigned tg = imm % 67108864;
    int n = 1;
    w0 = '0;
    w1 = '0;
    case (op)
      OpAddu:    w0 = rr(rs, rt, rd, 0, 33);
      OpAdd:     w0 = rr(rs, rt, rd, 0, 32);
      OpSubu:    w0 = rr(rs, rt, rd, 0, 35);
      OpSub:     w0 = rr(rs, rt, rd, 0, 34);
      OpAnd:     w0 = rr(rs, rt, rd, 0, 36);
      OpOr:      w0 = rr(rs, rt, rd, 0, 37);
      OpXor:     w0 = rr(rs, rt, rd, 0, 38);
      OpNor:     w0 = rr(rs, rt, rd, 0, 39);
      OpSlt:     w0 = rr(rs, rt, rd, 0, 42);
      OpSltu:    w0 = rr(rs, rt, rd, 0, 43);
      OpSll:     w0 = rr(0, rt, rd, sh, 0);
      OpSrl:     w0 = rr(0, rt, rd, sh, 2);
      OpSra:     w0 = rr(0, rt, rd, sh, 3);
      OpSllv:    w0 = rr(rs, rt, rd, 0, 4);
      OpSrlv:    w0 = rr(rs, rt, rd, 0, 6);
      OpSrav:    w0 = rr(rs, rt, rd, 0, 7);
      OpJr:      w0 = rr(rs, 0, 0, 0, 8);
      OpJalr:    w0 = rr(rs, 0, rd, 0, 9);
      OpSyscall: w0 = rr(0, 0, 0, 0, 12);
      OpNop:     w0 = 32'd0;
      OpAddiu:   w0 = ri(9, rs, rt, lo);
      OpAddi:    w0 = ri(8, rs, rt, lo);
      OpOri:     w0 = ri(13, rs, rt, lo);
      OpXori:    w0 = ri(14, rs, rt, lo);
      OpAndi:    w0 = ri(12, rs, rt, lo);
      OpSlti:    w0 = ri(10, rs, rt, lo);
      OpSltiu:   w0 = ri(11, rs, rt, lo);
      OpLw:      w0 = ri(35, rs, rt, lo);
      OpSw:      w0 = ri(43, rs, rt, lo);
      OpBeq:     w0 = ri(4, rs, rt, lo);
      OpBne:     w0 = ri(5, rs, rt, lo);
      OpBlez:    w0 = ri(6, rs, 0, lo);
      OpBgtz:    w0 = ri(7, rs, 0, lo);
      OpBltz:    w0 = ri(1, rs, 0, lo);
      OpBgez:    w0 = ri(1, rs, 1, lo);
      OpLui:     w0 = ri(15, 0, rt, lo);
      OpJ:       w0 = 32'(2 * 67108864 + tg);
      OpJal:     w0 = 32'(3 * 67108864 + tg);
      OpLi: begin
        if (hi == 0) w0 = ri(13, 0, rt, lo);
        else if (lo == 0) w0 = ri(15, 0, rt, hi);
        else begin
          w0 = ri(15, 0, rt, hi);
          w1 = ri(13, rt, rt, lo);
          n  = 2;
        end
      end
      default: n = 0;
    endcase
    return n;
  endfunction

  task automatic model_accept;
    logic [31:0] w0, w1;
    int n;
    n = ref_encode(bus.in_op, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_imm, w0, w1);
    if (n == 0 || n > int'(Depth - m_reserved)) begin
      m_err = 1'b1;
    end else begin
      m_q.push_back({m_next_addr, w0});
      m_next_addr += 32'd4;
      if (n == 2) begin
        m_q.push_back({m_next_addr, w1});
        m_next_addr += 32'd4;
      end
      m_reserved += n;
    end
  endtask

  // Scoreboard: handshakes seen half a cycle before the edge that completes them
  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("err_flag", 64'(err), 64'(m_err));
      check_eq("full_flag", 64'(full), 64'(m_reserved == Depth));
      if (bus.out_valid && bus.out_ready) begin
        check_eq("sb_pending", 64'(m_q.size() != 0), 64'd1);
        if (m_q.size() != 0) begin
          logic [63:0] e;
          e = m_q.pop_front();
          check_eq("sb_word", 64'(bus.out_word), 64'(e[31:0]));
          check_eq("sb_addr", 64'(bus.out_addr), 64'(e[63:32]));
        end
      end
      if (bus.in_valid && bus.in_ready) model_accept();
    end
  end

  initial begin
    bit was_acc;
    logic [31:0] v;
    set_req(6'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    bus2.in_op = OpNop; bus2.in_rs = '0; bus2.in_rt = '0; bus2.in_rd = '0; bus2.in_imm = '0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.out_ready = 1'b0;

    // Reset state
    tick;
    tick;
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_out_word", 64'(bus.out_word), 64'd0);
    check_eq("rst_out_addr", 64'(bus.out_addr), 64'(Base));
    check_eq("rst_full", 64'(full), 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);
    do_reset;

    // ADDU, latency one
    set_req(OpAddu, 5'd1, 5'd2, 5'd3, 32'd0);
    bus.in_valid = 1'b1;
    check_eq("addu_in_ready", 64'(bus.in_ready), 64'd1);
    tick;
    bus.in_valid = 1'b0;
    check_eq("addu_valid", 64'(bus.out_valid), 64'd1);
    check_eq("addu_word", 64'(bus.out_word), 64'h0022_1821);
    check_eq("addu_addr", 64'(bus.out_addr), 64'h3000);
    tick;
    check_eq("addu_drained", 64'(bus.out_valid), 64'd0);
    check_eq("addu_addr_inc", 64'(bus.out_addr), 64'h3004);

    // Two-word LI
    do_reset;
    set_req(OpLi, 5'd0, 5'd8, 5'd0, 32'h1234_5678);
    bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    check_eq("li2_w0", 64'(bus.out_word), 64'h3C08_1234);
    check_eq("li2_a0", 64'(bus.out_addr), 64'h3000);
    check_eq("li2_busy", 64'(bus.in_ready), 64'd0);
    tick;
    check_eq("li2_w1", 64'(bus.out_word), 64'h3508_5678);
    check_eq("li2_a1", 64'(bus.out_addr), 64'h3004);
    check_eq("li2_v1", 64'(bus.out_valid), 64'd1);
    tick;
    check_eq("li2_done", 64'(bus.out_valid), 64'd0);

    // Single-word LI then BGEZ back to back
    do_reset;
    set_req(OpLi, 5'd0, 5'd8, 5'd0, 32'h0000_BEEF);
    bus.in_valid = 1'b1;
    tick;
    check_eq("li1_word", 64'(bus.out_word), 64'h3408_BEEF);
    check_eq("li1_ready", 64'(bus.in_ready), 64'd1);
    set_req(OpBgez, 5'd2, 5'd0, 5'd0, 32'h0000_0004);
    tick;
    bus.in_valid = 1'b0;
    check_eq("bgez_word", 64'(bus.out_word), 64'h0441_0004);
    check_eq("bgez_addr", 64'(bus.out_addr), 64'h3004);
    tick;

    // Output stall holds the word
    do_reset;
    bus.out_ready = 1'b0;
    set_req(OpBeq, 5'd4, 5'd5, 5'd0, 32'h0000_FFFF);
    bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("stall_word", 64'(bus.out_word), 64'h1085_FFFF);
      check_eq("stall_valid", 64'(bus.out_valid), 64'd1);
      check_eq("stall_ready", 64'(bus.in_ready), 64'd0);
      tick;
    end
    bus.out_ready = 1'b1;
    tick;
    check_eq("stall_release", 64'(bus.out_valid), 64'd0);
    check_eq("stall_addr", 64'(bus.out_addr), 64'h3004);

    // Unknown op
    do_reset;
    set_req(6'h3F, 5'd1, 5'd1, 5'd1, 32'd1);
    bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    check_eq("unk_err", 64'(err), 64'd1);
    check_eq("unk_valid", 64'(bus.out_valid), 64'd0);
    tick;
    check_eq("unk_valid2", 64'(bus.out_valid), 64'd0);
    check_eq("unk_err_sticky", 64'(err), 64'd1);

    // Reset while in SECOND with a stalled output
    do_reset;
    bus.out_ready = 1'b0;
    set_req(OpLi, 5'd0, 5'd8, 5'd0, 32'h1234_5678);
    bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    tick;
    rst_n = 1'b0;
    tick;
    check_eq("rstmid_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rstmid_addr", 64'(bus.out_addr), 64'h3000);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick;
    tick;
    check_eq("rstmid_quiet", 64'(bus.out_valid), 64'd0);

    // Small memory: pair with one free slot, then fill
    do_reset;
    bus2.in_op = OpNop;
    bus2.in_valid = 1'b1;
    tick;
    check_eq("small_nop_valid", 64'(bus2.out_valid), 64'd1);
    check_eq("small_nop_word", 64'(bus2.out_word), 64'd0);
    bus2.in_op = OpLi; bus2.in_rt = 5'd8; bus2.in_imm = 32'h1234_5678;
    check_eq("small_li_ready", 64'(bus2.in_ready), 64'd1);
    tick;
    bus2.in_valid = 1'b0;
    check_eq("small_li_err", 64'(err2), 64'd1);
    check_eq("small_li_none", 64'(bus2.out_valid), 64'd0);
    check_eq("small_li_full", 64'(full2), 64'd0);
    bus2.in_op = OpNop;
    bus2.in_valid = 1'b1;
    tick;
    bus2.in_valid = 1'b0;
    check_eq("small_nop2_valid", 64'(bus2.out_valid), 64'd1);
    check_eq("small_full", 64'(full2), 64'd1);
    check_eq("small_ready", 64'(bus2.in_ready), 64'd0);
    check_eq("small_addr", 64'(bus2.out_addr), 64'h3004);
    tick;
    check_eq("small_full_hold", 64'(bus2.in_ready), 64'd0);

    // Randomized stream against the model
    do_reset;
    m_q.delete();
    m_reserved  = 0;
    m_err       = 1'b0;
    m_next_addr = Base;
    bus.in_valid = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 500; i++) begin
      was_acc = bus.in_valid && bus.in_ready;
      tick;
      if (!bus.in_valid || was_acc) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        if (i > 400 && $urandom_range(0, 29) == 0) bus.in_op = 6'($urandom_range(39, 63));
        else bus.in_op = 6'($urandom_range(0, NumOps - 1));
        bus.in_rs = 5'($urandom);
        bus.in_rt = 5'($urandom);
        bus.in_rd = 5'($urandom);
        v = $urandom;
        case ($urandom_range(0, 2))
          1: v[31:16] = 16'd0;
          2: v[15:0] = 16'd0;
          default: ;
        endcase
        bus.in_imm = v;
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick;
    check_eq("drain_empty", 64'(m_q.size()), 64'd0);
    check_eq("drain_addr", 64'(bus.out_addr), 64'(m_next_addr));
    mon_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_3000, byte address of the first emitted word.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, capacity of the target instruction memory in words.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  reset, synchronous, active-low.
REQ-005 in_valid  in  1  request present; in_ready  out  1  request accepted when both high at clk edge.
REQ-006 in_op  in  6  mnemonic code, enumerated in the shared package.
REQ-007 in_rs, in_rt, in_rd  in  5 each  register fields.
REQ-008 in_imm  in  32  immediate, shamt, jump target or 32-bit LI constant.
REQ-009 out_valid  out  1  word present; out_ready  in  1  word consumed when both high at clk edge.
REQ-010 out_word  out  32  encoded MIPS instruction; out_addr  out  32  its byte address.
REQ-011 full  out  1  all DEPTH_WORDS slots reserved; err  out  1  sticky error flag.

Function
REQ-012 Supported ops: ADDU ADD SUBU SUB AND OR XOR NOR SLT SLTU SLL SRL SRA SLLV SRLV SRAV JR JALR SYSCALL ADDIU ADDI ORI XORI ANDI SLTI SLTIU LW SW BEQ BNE BLEZ BGTZ BLTZ BGEZ LUI J JAL NOP LI; standard MIPS32 opcode/funct values.
REQ-013 Field rules: R-type rs/rt/rd from inputs, shamt 0; SLL/SRL/SRA rs=0, shamt=in_imm[4:0]; SLLV/SRLV/SRAV rs=in_rs (amount), rt=in_rt; JR rd=rt=0; JALR rt=0; SYSCALL/NOP all-zero except funct.
REQ-014 I-type uses in_imm[15:0] unmodified; BLTZ opcode 000001 rt=0, BGEZ rt=1; BLEZ/BGTZ rt=0; LUI rs=0; J/JAL target=in_imm[25:0]; upper in_imm bits ignored, no range check.
REQ-015 LI expansion: in_imm[31:16]==0 -> one word ORI rt,$0,lo; else in_imm[15:0]==0 -> one word LUI rt,hi; else two words LUI rt,hi then ORI rt,rt,lo.
REQ-016 FSM states IDLE, SECOND; IDLE->SECOND on accepting two-word LI; SECOND->IDLE when second word loads into output register.
REQ-017 Single output register; word accepted at edge N appears with out_valid=1 after edge N (latency 1).
REQ-018 out_word/out_addr SHALL hold stable while out_valid=1 and out_ready=0.
REQ-019 in_ready = (state==IDLE) and (out_valid==0 or out_ready==1) and (full==0); back-to-back throughput one word/cycle.
REQ-020 out_addr increments by 4 after each out handshake; slot reservation counter increments at acceptance by words generated.
REQ-021 full asserts when reserved count equals DEPTH_WORDS; no wrap-around; stays set until reset.
REQ-022 Unknown in_op: request consumed, no word emitted, err set.
REQ-023 Two-word LI accepted with exactly one free slot: request consumed, no word emitted, err set, counter unchanged.
REQ-024 err never clears except by reset.

Reset
REQ-025 While reset=0 at clk edge: out_valid=0, out_word=0, out_addr=BASE_ADDR, state=IDLE, reserved=0, full=0, err=0.
REQ-026 Reset mid-operation (including SECOND or stalled output) SHALL discard pending words with no further output.

Structure
REQ-027 Op enumeration, opcode and funct constants SHALL live in the shared constants package, reusable by the decoder side.
REQ-028 Single-word field packing SHALL be a combinational sub-module instr_field_pack; FSM, counters and output register stay in instr_encoder.

Verification
REQ-029 ADDU rd=3 rs=1 rt=2, out_ready=1 -> next cycle out_word=0x00221821, out_addr=0x3000.
REQ-030 LI rt=8 imm=0x12345678 -> 0x3C081234 @0x3000 then 0x35085678 @0x3004; in_ready=0 during SECOND.
REQ-031 LI rt=8 imm=0x0000BEEF -> single word 0x3408BEEF; BGEZ rs=2 imm=0x0004 -> 0x04410004.
REQ-032 BEQ rs=4 rt=5 imm=0xFFFF with out_ready=0 for 3 cycles -> out_word stable 0x1085FFFF, in_ready=0, one word emitted after release.
REQ-033 DEPTH_WORDS=2: NOP then two-word LI -> err=1, one word emitted; then NOP -> full=1, in_ready=0.
REQ-034 in_op=6'h3F -> err=1, out_valid stays 0; reset=0 during SECOND -> out_valid=0, out_addr=0x3000 next cycle.
